poly_product_reducer: RTL and testbench
=======================================

# poly_product_reducer

Sequential back end for the Karatsuba polynomial multiplier. It accepts one full unreduced product polynomial: 2D−1 coefficients, each 2N bits wide, on the multiplier's output bus format. It reduces the product modulo (x^D + 1) and modulo Q, then streams the D resulting N-bit coefficients out one per handshake. It sits between the multiplier output and any downstream NTT/coefficient consumer, turning the wide double-width product back into ring-element coefficients.

## Interface
- N, 2, coefficient width of the reduced ring element (product coefficients are 2N bits)
- D, 4, number of ring coefficients (ring is Z_Q[x]/(x^D+1)); D ≥ 2, power of two
- Q, 3, coefficient modulus; 2 ≤ Q < 2^N
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  product bus holds a valid product
- in_ready  output  1  block can accept a product
- in_p  input  (2D−1)·2N  product coefficients; coefficient i at bits [2N·i +: 2N], i=0 in LSBs
- out_valid  output  1  out_coef holds a valid reduced coefficient
- out_ready  input  1  consumer accepts current coefficient
- out_coef  output  N  reduced coefficient, range 0..Q−1
- out_idx  output  max(1,clog2(D))  index of out_coef, 0..D−1
- out_last  output  1  high with out_valid when out_idx = D−1

## Operation
- FSM states: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. On in_valid & in_ready: capture in_p into the product buffer, clear idx to 0, go to SEND.
- SEND: in_ready=0, out_valid=1. out_coef is computed from the buffer and idx:
  - hi = p[idx+D] if idx+D ≤ 2D−2, else 0
  - lo_r = p[idx] mod Q; hi_r = hi mod Q
  - out_coef = lo_r − hi_r if lo_r ≥ hi_r, else lo_r − hi_r + Q
- Arithmetic: p values are unsigned 2N-bit values. Reduction by the constant Q is combinational. The result is always in 0..Q−1. No overflow is possible in the difference path, which is N+1 bits internally.
- On out_valid & out_ready in SEND:
  - if idx = D−1, go to IDLE (out_last was high)
  - otherwise idx ← idx+1
- Backpressure: while out_valid & !out_ready, out_coef, out_idx and out_last hold stable and the buffer is unchanged.
- in_valid is ignored in SEND. The upstream source must hold its data until in_ready, which is standard valid/ready.
- A new product is accepted only from IDLE. The block does not overlap consecutive products.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, idx=0, buffer=0
  - in_ready=1, out_valid=0, out_coef=0, out_idx=0, out_last=0
- Reset mid-SEND discards the in-flight product. No further coefficients are emitted.
- Latency: product accepted at edge t → out_valid=1 with idx 0 during the cycle after t.
- Throughput: with out_ready held high, D coefficients appear on D consecutive cycles. in_ready returns to 1 the cycle after the out_last handshake, so a full product takes D+1 cycles.
- in_ready and out_valid are never both 1.
- in_ready and out_valid are registered-state decodes only. There is no combinational path from out_ready or in_valid to any output.

## Test plan
- Basic, no wrap (N=2, D=4, Q=3): a=1+x, b=1+x, giving in_p coefficients p0..p6 = 1,2,1,0,0,0,0. Hold out_ready=1. Required: out_coef 1,2,1,0 with idx 0..3, out_last only on idx 3, in_ready back at 1 on the 5th cycle after accept.
- Negacyclic wrap: in_p coefficients p4=1, all others 0 (x^3·x). Required: out_coef 2,0,0,0, since −1 mod 3 = 2.
- Mod reduction, max values: all p_i = 15. Required: every output is 0, because 15 mod 3 = 0 and 0 − 0 = 0. Also p0=14, p4=13 (others 0) gives c0 = (2−1) mod 3 = 1.
- Backpressure: toggle out_ready 1,0,0,1,… pseudo-randomly. Required: out_coef and out_idx stable while stalled, no coefficient skipped or repeated, in_valid pulses during SEND ignored.
- Reset mid-operation: deassert rst_n asynchronously (mid-cycle) after 2 coefficients are accepted. Required: out_valid=0 and in_ready=1 immediately. After release, a new product is accepted and streamed from idx 0 correctly.
- Back-to-back products: in_valid held high with two different products. Required: the second is accepted exactly on the cycle in_ready returns, and both D-coefficient streams match a reference model of (p mod (x^D+1)) mod Q.

Source files
------------

// File: rtl/poly_product_reducer.sv
// Back end of the Karatsuba multiplier: folds a (2D-1)-term double-width product
// modulo (x^D + 1) and Q, then streams the D ring coefficients over valid/ready.
module poly_product_reducer #(
    parameter int N = 2,
    parameter int D = 4,
    parameter int Q = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [(2*D-1)*2*N-1:0]           in_p,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N-1:0]                     out_coef,
    output logic [(($clog2(D) < 1) ? 1 : $clog2(D))-1:0] out_idx,
    output logic                             out_last
);

    localparam int CW = 2 * N;
    localparam int PW = (2 * D - 1) * CW;
    localparam int IW = ($clog2(D) < 1) ? 1 : $clog2(D);
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   idx_nx_s;
    logic [PW-1:0]   buf_r;
    logic [PW-1:0]   src_s;
    logic            load_s;
    logic [N-1:0]    coef_r;
    logic [N-1:0]    coef_nx_s;
    logic            last_r;
    logic            last_nx_s;
    logic            in_ready_r;
    logic            out_valid_r;

    // Ring coefficient idx: p[idx] - p[idx+D] folded into 0..Q-1; the top index has no wrap partner.
    function automatic logic [N-1:0] reduce_coef(input logic [PW-1:0] p, input logic [IW-1:0] idx);
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic [N-1:0]  lo_m;
        logic [N-1:0]  hi_m;
        logic [N:0]    lo_e;
        logic [N:0]    hi_e;
        logic [N:0]    diff;
        lo = CW'(p >> (CW * int'(idx)));
        if (idx != LAST_IDX) begin
            hi = CW'(p >> (CW * (int'(idx) + D)));
        end else begin
            hi = '0;
        end
        lo_m = N'(lo % CW'(Q));
        hi_m = N'(hi % CW'(Q));
        lo_e = {1'b0, lo_m};
        hi_e = {1'b0, hi_m};
        if (lo_e >= hi_e) begin
            diff = lo_e - hi_e;
        end else begin
            diff = lo_e + (N+1)'(Q) - hi_e;
        end
        return N'(diff);
    endfunction

    // Next-state and coefficient selection; the output register is loaded with the coefficient for the next index.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        load_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = SEND;
                    idx_nx_s   = '0;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = IDLE;
                        idx_nx_s   = '0;
                    end else begin
                        idx_nx_s = idx_r + 1'b1;
                    end
                end else begin
                    state_nx_s = SEND;
                end
            end
            default: begin
                state_nx_s = IDLE;
                idx_nx_s   = '0;
            end
        endcase
        if (load_s) begin
            src_s = in_p;
        end else begin
            src_s = buf_r;
        end
        coef_nx_s = reduce_coef(src_s, idx_nx_s);
        last_nx_s = (state_nx_s == SEND) && (idx_nx_s == LAST_IDX);
    end

    // State, product buffer and registered handshake/coefficient outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            buf_r       <= '0;
            coef_r      <= '0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            idx_r       <= idx_nx_s;
            coef_r      <= coef_nx_s;
            last_r      <= last_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == SEND);
            if (load_s) begin
                buf_r <= in_p;
            end else begin
                buf_r <= buf_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_coef  = coef_r;
    assign out_idx   = idx_r;
    assign out_last  = last_r;

    poly_product_reducer_checker #(
        .N  (N),
        .Q  (Q),
        .IW (IW)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

endmodule

// Protocol properties of the reducer output stream.
module poly_product_reducer_checker #(
    parameter int N  = 2,
    parameter int Q  = 3,
    parameter int IW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          in_ready,
    input logic          out_valid,
    input logic          out_ready,
    input logic [N-1:0]  out_coef,
    input logic [IW-1:0] out_idx,
    input logic          out_last
);

    a_exclusive_handshake: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_coef_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (int'(out_coef) < Q));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_coef) && $stable(out_idx) && $stable(out_last)));

endmodule

// File: tb/tb_poly_product_reducer.sv
// Directed bench for poly_product_reducer (N=2, D=4, Q=3) with hand-computed expectations.
module tb_poly_product_reducer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_p;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_coef;
    logic [1:0]  out_idx;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    poly_product_reducer #(.N(2), .D(4), .Q(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] pk(input int p0, input int p1, input int p2, input int p3,
                                       input int p4, input int p5, input int p6);
        return {4'(p6), 4'(p5), 4'(p4), 4'(p3), 4'(p2), 4'(p1), 4'(p0)};
    endfunction

    // Reference: signed negacyclic fold first, then a single mod 3 at the end.
    function automatic logic [7:0] model(input logic [27:0] v);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = int'(v[4*i +: 4]);
            if (i + 4 <= 6) s = s - int'(v[4*(i+4) +: 4]);
            s = ((s % 3) + 3) % 3;
            r[2*i +: 2] = 2'(s);
        end
        return r;
    endfunction

    task automatic accept(input logic [27:0] v, input bit hold, input string tag);
        int n;
        n = 0;
        in_p     = v;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic stream_expect(input logic [7:0] e, input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("%s_valid%0d", tag, k), out_valid, 1);
            chk($sformatf("%s_idx%0d", tag, k), out_idx, k);
            chk($sformatf("%s_coef%0d", tag, k), out_coef, e[2*k +: 2]);
            chk($sformatf("%s_last%0d", tag, k), out_last, (k == 3) ? 1 : 0);
            chk($sformatf("%s_inrdy%0d", tag, k), in_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({tag, "_end_valid"}, out_valid, 0);
        chk({tag, "_end_inrdy"}, in_ready, 1);
    endtask

    initial begin
        logic [27:0] va;
        logic [27:0] vb;
        logic [7:0]  e;
        logic [15:0] pat;
        int          idx;
        int          cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_p      = 28'd0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_coef", out_coef, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // (1+x)^2, no wrap
        out_ready = 1'b1;
        accept(pk(1, 2, 1, 0, 0, 0, 0), 1'b0, "basic");
        stream_expect({2'd0, 2'd1, 2'd2, 2'd1}, "basic");

        // x^4 folds to -1
        accept(pk(0, 0, 0, 0, 1, 0, 0), 1'b0, "wrap");
        stream_expect({2'd0, 2'd0, 2'd0, 2'd2}, "wrap");

        accept(pk(15, 15, 15, 15, 15, 15, 15), 1'b0, "max");
        stream_expect(8'd0, "max");

        accept(pk(14, 0, 0, 0, 13, 0, 0), 1'b0, "mod");
        stream_expect({2'd0, 2'd0, 2'd0, 2'd1}, "mod");

        // Backpressure with stray in_valid pulses; coefs 1,2,2,0
        e   = {2'd0, 2'd2, 2'd2, 2'd1};
        pat = 16'b1010_1110_0101_1001;
        accept(pk(5, 7, 2, 9, 4, 11, 3), 1'b0, "bp");
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            out_ready = pat[cyc % 16];
            in_valid  = (cyc % 2 == 1);
            in_p      = pk(1, 1, 1, 1, 1, 1, 1);
            @(negedge clk);
            chk($sformatf("bp_valid_c%0d", cyc), out_valid, 1);
            chk($sformatf("bp_idx_c%0d", cyc), out_idx, idx);
            chk($sformatf("bp_coef_c%0d", cyc), out_coef, e[2*(idx % 4) +: 2]);
            chk($sformatf("bp_last_c%0d", cyc), out_last, (idx == 3) ? 1 : 0);
            @(posedge clk);
            if (out_ready) idx++;
            #1;
            in_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b1;
        chk("bp_all_sent", idx, 4);
        @(negedge clk);
        chk("bp_end_valid", out_valid, 0);
        chk("bp_end_inrdy", in_ready, 1);

        // Asynchronous reset after two coefficients handshaken
        accept(pk(1, 2, 1, 0, 0, 0, 0), 1'b0, "rst");
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_coef0", out_coef, 1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_idx1", out_idx, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_inrdy", in_ready, 1);
        chk("rst_mid_idx", out_idx, 0);
        chk("rst_mid_coef", out_coef, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_after_valid", out_valid, 0);
        accept(pk(0, 0, 0, 0, 1, 0, 0), 1'b0, "post_rst");
        stream_expect({2'd0, 2'd0, 2'd0, 2'd2}, "post_rst");

        // Back-to-back with in_valid held high
        va = pk(3, 1, 4, 1, 5, 9, 2);
        vb = pk(6, 14, 0, 8, 1, 2, 13);
        chk("model_a", model(va), {2'd1, 2'd2, 2'd1, 2'd1});
        chk("model_b", model(vb), {2'd2, 2'd2, 2'd0, 2'd2});
        accept(va, 1'b1, "b2b_a");
        in_p = vb;
        stream_expect(model(va), "b2b_a");
        chk("b2b_b_pending", in_valid, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stream_expect(model(vb), "b2b_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
